// File: rtl/pu_riscv_fifo_pkg.sv
// Shared sizing helpers for the RAM-backed show-ahead FIFO controller.
package pu_riscv_fifo_pkg;

    // Number of entries held by a FIFO with an abits-wide RAM address.
    function automatic int fifo_capacity(input int abits);
        return 1 << abits;
    endfunction

    // Number of byte lanes needed to cover a dbits-wide data word.
    function automatic int be_width(input int dbits);
        return (dbits + 7) / 8;
    endfunction

endpackage

// File: rtl/pu_riscv_fifo_ptr.sv
// Wrapping ABITS-bit pointer with increment and synchronous clear.
// Clear takes priority over increment.
module pu_riscv_fifo_ptr
    import pu_riscv_fifo_pkg::*;
#(
    parameter int ABITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [ABITS-1:0] ptr_o
);

    logic [ABITS-1:0] ptr_q;
    logic [ABITS-1:0] ptr_d;

    // Next pointer: clear to zero, else advance by one with natural wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + ABITS'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/pu_riscv_ram_fifo_ctrl.sv
// Show-ahead FIFO controller driving an external 1r1w synchronous RAM.
// The RAM is always addressed with the read pointer of the coming cycle,
// so its output is the head entry; a one-entry bypass register covers
// writes to the address being read in the same cycle.
// Optional macro PU_RISCV_FIFO_ERR_EN adds sticky ovf_o/unf_o flags.
module pu_riscv_ram_fifo_ctrl
    import pu_riscv_fifo_pkg::*;
#(
    parameter int ABITS = 4,
    parameter int DBITS = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DBITS-1:0]           din_i,
    output logic                       full_o,
    input  logic                       pop_i,
    output logic [DBITS-1:0]           dout_o,
    output logic                       empty_o,
    output logic [ABITS:0]             usedw_o,
    output logic [ABITS-1:0]           ram_waddr_o,
    output logic [DBITS-1:0]           ram_din_o,
    output logic                       ram_we_o,
    output logic [be_width(DBITS)-1:0] ram_be_o,
    output logic [ABITS-1:0]           ram_raddr_o,
`ifdef PU_RISCV_FIFO_ERR_EN
    output logic                       ovf_o,
    output logic                       unf_o,
`endif
    input  logic [DBITS-1:0]           ram_dout_i
);

    localparam int CAP = fifo_capacity(ABITS);

    logic             push_ok;
    logic             pop_ok;
    logic [ABITS-1:0] wr_ptr;
    logic [ABITS-1:0] rd_ptr;
    logic [ABITS-1:0] rd_ptr_nxt;
    logic [ABITS:0]   count_q, count_d;
    logic             bypass_q, bypass_d;
    logic [DBITS-1:0] bypass_data_q, bypass_data_d;

    // Flags come from registered count only, so a pop while full cannot
    // make room for a push in the same cycle. Flush suppresses both.
    assign full_o  = (count_q == (ABITS+1)'(CAP));
    assign empty_o = (count_q == '0);
    assign usedw_o = count_q;
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    pu_riscv_fifo_ptr #(.ABITS(ABITS)) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (push_ok),
        .ptr_o  (wr_ptr)
    );

    pu_riscv_fifo_ptr #(.ABITS(ABITS)) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (pop_ok),
        .ptr_o  (rd_ptr)
    );

    assign rd_ptr_nxt  = rd_ptr + ABITS'(pop_ok);
    assign ram_raddr_o = rd_ptr_nxt;
    assign ram_waddr_o = wr_ptr;
    assign ram_din_o   = din_i;
    assign ram_we_o    = push_ok;
    assign ram_be_o    = '1;

    assign dout_o = bypass_q ? bypass_data_q : ram_dout_i;

    // Occupancy update and capture of writes that collide with the read address.
    always_comb begin
        count_d       = count_q + (ABITS+1)'(push_ok) - (ABITS+1)'(pop_ok);
        bypass_d      = ram_we_o & (ram_waddr_o == ram_raddr_o);
        bypass_data_d = bypass_data_q;
        if (bypass_d) begin
            bypass_data_d = din_i;
        end
        if (flush_i) begin
            count_d  = '0;
            bypass_d = 1'b0;
        end
    end

    // Count and bypass registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q       <= '0;
            bypass_q      <= 1'b0;
            bypass_data_q <= '0;
        end else begin
            count_q       <= count_d;
            bypass_q      <= bypass_d;
            bypass_data_q <= bypass_data_d;
        end
    end

`ifdef PU_RISCV_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Sticky misuse flags, cleared only by flush.
    always_comb begin
        ovf_d = ovf_q | (push_i & full_o);
        unf_d = unf_q | (pop_i & empty_o);
        if (flush_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    // Misuse flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf_o = ovf_q;
    assign unf_o = unf_q;
`endif

endmodule
